// File: rtl/fp_normalize_pipe.sv
`timescale 1ns/1ps
// fp_normalize_pipe: two-stage normalize-and-round unit for the FP adder.
// Stage 1 normalizes the aligned sum; stage 2 rounds, packs the result and
// raises exception flags. Both stages use a valid/ready handshake with full backpressure.
module fp_normalize_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [MAN_W+8:0]       in_sum,
    input  logic                   in_carry,
    input  logic [1:0]             in_rmode,
    input  logic                   in_special,
    input  logic [EXP_W+MAN_W:0]   in_special_val,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_overflow,
    output logic                   out_underflow,
    output logic                   out_inexact
);

    localparam int SUM_W = MAN_W + 9;
    localparam int RES_W = 1 + EXP_W + MAN_W;
    localparam int LZ_W  = $clog2(SUM_W + 1);
    localparam int CMP_W = ((LZ_W > EXP_W) ? LZ_W : EXP_W) + 1;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } rmode_e;

    // handshake
    logic w_s1_take, w_s2_take;
    logic r1_valid, r2_valid;

    assign w_s2_take = ~r2_valid | out_ready;
    assign w_s1_take = ~r1_valid | w_s2_take;
    assign in_ready  = w_s1_take;

    // stage 1 combinational signals
    logic [LZ_W-1:0]  w_lzc;
    logic [CMP_W-1:0] w_lzc_x, w_exp_x, w_shift;
    logic [SUM_W-1:0] w_shifted;
    logic [EXP_W:0]   w_n_exp;
    logic [MAN_W-1:0] w_n_man;
    logic             w_n_hid, w_n_g, w_n_r, w_n_s, w_n_zero;

    // stage 1 registers
    logic             r1_sign, r1_hid, r1_g, r1_r, r1_s, r1_zero, r1_special;
    logic [EXP_W:0]   r1_exp;
    logic [MAN_W-1:0] r1_man;
    rmode_e           r1_rmode;
    logic [RES_W-1:0] r1_sval;

    // Leading-zero count of the aligned sum (SUM_W when the sum is zero).
    always_comb begin
        w_lzc = LZ_W'(SUM_W);
        for (int unsigned i = 0; i < SUM_W; i++) begin
            if (in_sum[i]) w_lzc = LZ_W'(SUM_W - 1 - i);
        end
    end

    // Normalize: pick shift and exponent, extract hidden/mantissa/G/R/S.
    always_comb begin
        w_lzc_x   = CMP_W'(w_lzc);
        w_exp_x   = CMP_W'(in_exp);
        w_shift   = '0;
        w_shifted = in_sum;
        w_n_exp   = '0;
        w_n_hid   = 1'b0;
        w_n_man   = '0;
        w_n_g     = 1'b0;
        w_n_r     = 1'b0;
        w_n_s     = 1'b0;
        w_n_zero  = ~in_carry & ~(|in_sum);
        if (in_carry) begin
            w_n_exp = (EXP_W+1)'(in_exp) + (EXP_W+1)'(1);
            w_n_hid = 1'b1;
            w_n_man = in_sum[SUM_W-1:9];
            w_n_g   = in_sum[8];
            w_n_r   = in_sum[7];
            w_n_s   = |in_sum[6:0];
        end else begin
            if (w_lzc_x < w_exp_x) begin
                w_shift = w_lzc_x;
                w_n_exp = (EXP_W+1)'(w_exp_x - w_lzc_x);
            end else begin
                // subnormal: shift only as far as the minimum exponent allows
                w_n_exp = '0;
                w_shift = (in_exp == '0) ? '0 : (w_exp_x - CMP_W'(1));
            end
            w_shifted = in_sum << w_shift;
            w_n_hid   = w_shifted[SUM_W-1];
            w_n_man   = w_shifted[SUM_W-2:8];
            w_n_g     = w_shifted[7];
            w_n_r     = w_shifted[6];
            w_n_s     = |w_shifted[5:0];
        end
    end

    // Stage 1 valid bit: loads on take.
    always_ff @(posedge clk) begin
        if (!rst_n)         r1_valid <= 1'b0;
        else if (w_s1_take) r1_valid <= in_valid;
    end

    // Stage 1 data: captured only when a beat is accepted.
    always_ff @(posedge clk) begin
        if (w_s1_take && in_valid) begin
            r1_sign    <= in_sign;
            r1_exp     <= w_n_exp;
            r1_hid     <= w_n_hid;
            r1_man     <= w_n_man;
            r1_g       <= w_n_g;
            r1_r       <= w_n_r;
            r1_s       <= w_n_s;
            r1_zero    <= w_n_zero;
            r1_rmode   <= rmode_e'(in_rmode);
            r1_special <= in_special;
            r1_sval    <= in_special_val;
        end
    end

    // stage 2 combinational signals
    logic             w_inc, w_grs, w_ovf, w_unf;
    logic [MAN_W+1:0] w_rnd;
    logic [EXP_W:0]   w_f_exp;
    logic [MAN_W-1:0] w_f_man;
    logic [RES_W-1:0] w_inf, w_maxf, w_res;
    logic             w_o_ovf, w_o_unf, w_o_inx;

    // Round, detect overflow/underflow and select the packed result.
    always_comb begin
        w_grs = r1_g | r1_r | r1_s;
        w_inc = 1'b0;
        case (r1_rmode)
            RM_RNE:  w_inc = r1_g & (r1_r | r1_s | r1_man[0]);
            RM_RTZ:  w_inc = 1'b0;
            RM_RUP:  w_inc = ~r1_sign & w_grs;
            default: w_inc = r1_sign & w_grs;
        endcase
        w_rnd   = {1'b0, r1_hid, r1_man} + (MAN_W+2)'(w_inc);
        w_f_man = w_rnd[MAN_W-1:0];
        w_f_exp = r1_exp;
        if (w_rnd[MAN_W+1]) begin
            w_f_man = '0;
            w_f_exp = r1_exp + (EXP_W+1)'(1);
        end else if (r1_exp == '0 && w_rnd[MAN_W]) begin
            w_f_exp = (EXP_W+1)'(1);
        end
        w_ovf  = w_f_exp >= {1'b0, {EXP_W{1'b1}}};
        w_unf  = (w_f_exp == '0) & w_grs;
        w_inf  = {r1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_maxf = {r1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

        w_res   = {r1_sign, w_f_exp[EXP_W-1:0], w_f_man};
        w_o_ovf = 1'b0;
        w_o_unf = w_unf;
        w_o_inx = w_grs;
        if (r1_special) begin
            w_res   = r1_sval;
            w_o_unf = 1'b0;
            w_o_inx = 1'b0;
        end else if (r1_zero) begin
            w_res   = {(r1_rmode == RM_RDN), {(RES_W-1){1'b0}}};
            w_o_unf = 1'b0;
            w_o_inx = 1'b0;
        end else if (w_ovf) begin
            w_o_ovf = 1'b1;
            w_o_unf = 1'b0;
            w_o_inx = 1'b1;
            case (r1_rmode)
                RM_RNE:  w_res = w_inf;
                RM_RTZ:  w_res = w_maxf;
                RM_RUP:  w_res = r1_sign ? w_maxf : w_inf;
                default: w_res = r1_sign ? w_inf : w_maxf;
            endcase
        end
    end

    // stage 2 / output registers
    logic [RES_W-1:0] r2_result;
    logic             r2_ovf, r2_unf, r2_inx;

    // Output stage: holds its beat while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r2_valid  <= 1'b0;
            r2_result <= '0;
            r2_ovf    <= 1'b0;
            r2_unf    <= 1'b0;
            r2_inx    <= 1'b0;
        end else if (w_s2_take) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_result <= w_res;
                r2_ovf    <= w_o_ovf;
                r2_unf    <= w_o_unf;
                r2_inx    <= w_o_inx;
            end
        end
    end

    assign out_valid     = r2_valid;
    assign out_result    = r2_result;
    assign out_overflow  = r2_ovf;
    assign out_underflow = r2_unf;
    assign out_inexact   = r2_inx;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
`timescale 1ns/1ps
// Bench for fp_normalize_pipe: directed plan vectors, backpressure and reset
// scenarios, then random beats checked against an arithmetic reference model.
module tb_fp_normalize_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_sign, in_carry, in_special;
    logic [7:0]  in_exp;
    logic [31:0] in_sum, in_special_val, out_result;
    logic [1:0]  in_rmode;
    logic        out_valid, out_ready, out_overflow, out_underflow, out_inexact;

    always #5 clk = ~clk;

    fp_normalize_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_sum(in_sum), .in_carry(in_carry),
        .in_rmode(in_rmode), .in_special(in_special), .in_special_val(in_special_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
    );

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [31:0] sum;
        logic        carry;
        logic [1:0]  rm;
        logic        sp;
        logic [31:0] sv;
    } beat_t;

    // expected entries: {overflow, underflow, inexact, result}
    logic [34:0] exp_q[$];
    logic [34:0] mon_e;
    int          total = 0;
    int          bad   = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res = 32'h0;
    logic        rnd_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic beat_t mk(input logic s, input logic [7:0] e, input logic [31:0] sm,
                                 input logic c, input logic [1:0] rm, input logic sp,
                                 input logic [31:0] sv);
        beat_t b;
        b.sign = s; b.exp = e; b.sum = sm; b.carry = c; b.rm = rm; b.sp = sp; b.sv = sv;
        return b;
    endfunction

    // Reference: value-level rounding of the kept integer against the discarded remainder.
    function automatic logic [34:0] ref_model(input beat_t b);
        longint unsigned sum64, full, kept, rem, half;
        int   ex, lz, sh;
        logic up, inx;
        logic [31:0] res, inf_v, max_v;
        if (b.sp) return {3'b000, b.sv};
        if (!b.carry && b.sum == 32'h0) return {3'b000, (b.rm == 2'd3), 31'd0};
        sum64 = 64'(b.sum);
        if (b.carry) begin
            kept = (64'd1 << 23) | (sum64 >> 9);
            rem  = sum64 & 64'h1FF;
            half = 64'h100;
            ex   = int'(b.exp) + 1;
        end else begin
            lz = 0;
            while (((sum64 >> (31 - lz)) & 64'd1) == 64'd0) lz++;
            if (lz < int'(b.exp)) begin
                sh = lz;
                ex = int'(b.exp) - lz;
            end else begin
                ex = 0;
                sh = (b.exp == 8'h0) ? 0 : int'(b.exp) - 1;
            end
            full = (sum64 << sh) & 64'hFFFF_FFFF;
            kept = full >> 8;
            rem  = full & 64'hFF;
            half = 64'h80;
        end
        inx = (rem != 64'd0);
        case (b.rm)
            2'd0:    up = (rem > half) || (rem == half && kept[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = !b.sign && inx;
            default: up = b.sign && inx;
        endcase
        kept = kept + 64'(up);
        if (kept >= (64'd1 << 24)) begin
            kept = 64'd0;
            ex++;
        end else if (ex == 0 && kept >= (64'd1 << 23)) begin
            ex = 1;
        end
        inf_v = {b.sign, 8'hFF, 23'd0};
        max_v = {b.sign, 8'hFE, 23'h7FFFFF};
        if (ex >= 255) begin
            case (b.rm)
                2'd0:    res = inf_v;
                2'd1:    res = max_v;
                2'd2:    res = b.sign ? max_v : inf_v;
                default: res = b.sign ? inf_v : max_v;
            endcase
            return {3'b101, res};
        end
        res = {b.sign, 8'(ex), kept[22:0]};
        return {1'b0, (ex == 0) && inx, inx, res};
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.sign = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
            0:       b.exp = 8'h00;
            1:       b.exp = 8'h01;
            2:       b.exp = 8'hFE;
            3:       b.exp = 8'hFF;
            default: b.exp = 8'($urandom);
        endcase
        b.sum = 32'($urandom) >> $urandom_range(0, 31);
        if ($urandom_range(0, 15) == 0) b.sum = 32'h0;
        b.carry = ($urandom_range(0, 3) == 0);
        b.rm    = 2'($urandom_range(0, 3));
        b.sp    = ($urandom_range(0, 9) == 0);
        b.sv    = 32'($urandom);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input beat_t b);
        in_sign = b.sign; in_exp = b.exp; in_sum = b.sum; in_carry = b.carry;
        in_rmode = b.rm; in_special = b.sp; in_special_val = b.sv;
        in_valid = 1'b1;
    endtask

    // Present a beat, wait (bounded) for acceptance, queue its expected result.
    task automatic send(input beat_t b, input logic [34:0] expv);
        int unsigned n;
        drive(b);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("accept", 64'(in_ready), 64'h1);
        if (in_ready) exp_q.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Output monitor: in-order scoreboard plus stability of stalled outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && out_valid) check("hold", 64'(out_result), 64'(prev_res));
            if (out_valid && out_ready) begin
                check("expected_present", 64'(exp_q.size() != 0), 64'h1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("result", 64'(out_result), 64'(mon_e[31:0]));
                    check("flags", 64'({out_overflow, out_underflow, out_inexact}), 64'(mon_e[34:32]));
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_res   <= out_result;
        end
    end

    initial begin
        beat_t       rb;
        int unsigned n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = 8'h0; in_sum = 32'h0; in_carry = 1'b0;
        in_rmode = 2'd0; in_special = 1'b0; in_special_val = 32'h0;
        repeat (3) tick();
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_result", 64'(out_result), 64'h0);
        check("rst_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'h0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'h1);
        out_ready = 1'b1;
        tick();

        // latency of the first beat
        send(mk(1'b0, 8'h7F, 32'h8000_0000, 1'b0, 2'd0, 1'b0, 32'h0), {3'b000, 32'h3F80_0000});
        check("lat_1cyc", 64'(out_valid), 64'h0);
        tick();
        check("lat_2cyc", 64'(out_valid), 64'h1);
        check("lat_result", 64'(out_result), 64'h3F80_0000);

        // directed plan vectors, streamed back to back
        send(mk(1'b0, 8'h7F, 32'h0000_0000, 1'b1, 2'd0, 1'b0, 32'h0), {3'b000, 32'h4000_0000});
        send(mk(1'b0, 8'h7F, 32'h8000_0180, 1'b0, 2'd0, 1'b0, 32'h0), {3'b001, 32'h3F80_0002});
        send(mk(1'b0, 8'h7F, 32'h8000_0180, 1'b0, 2'd1, 1'b0, 32'h0), {3'b001, 32'h3F80_0001});
        send(mk(1'b0, 8'hFE, 32'h0000_0000, 1'b1, 2'd0, 1'b0, 32'h0), {3'b101, 32'h7F80_0000});
        send(mk(1'b0, 8'hFE, 32'h0000_0000, 1'b1, 2'd1, 1'b0, 32'h0), {3'b101, 32'h7F7F_FFFF});
        send(mk(1'b1, 8'hFE, 32'h0000_0000, 1'b1, 2'd2, 1'b0, 32'h0), {3'b101, 32'hFF7F_FFFF});
        send(mk(1'b0, 8'h01, 32'h4000_0000, 1'b0, 2'd0, 1'b0, 32'h0), {3'b000, 32'h0040_0000});
        send(mk(1'b1, 8'h80, 32'h0000_0000, 1'b0, 2'd0, 1'b0, 32'h0), {3'b000, 32'h0000_0000});
        send(mk(1'b0, 8'h80, 32'h0000_0000, 1'b0, 2'd3, 1'b0, 32'h0), {3'b000, 32'h8000_0000});
        send(mk(1'b0, 8'hFE, 32'h1234_5678, 1'b1, 2'd0, 1'b1, 32'h7FC0_0000), {3'b000, 32'h7FC0_0000});
        repeat (4) tick();

        // backpressure: two accepts fill the pipe, then in_ready drops
        out_ready = 1'b0;
        send(mk(1'b0, 8'h7F, 32'h0000_0000, 1'b1, 2'd0, 1'b0, 32'h0), {3'b000, 32'h4000_0000});
        send(mk(1'b0, 8'h7F, 32'h8000_0180, 1'b0, 2'd0, 1'b0, 32'h0), {3'b001, 32'h3F80_0002});
        drive(mk(1'b0, 8'h7F, 32'h8000_0180, 1'b0, 2'd1, 1'b0, 32'h0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'h0);
            check("bp_valid", 64'(out_valid), 64'h1);
            check("bp_held", 64'(out_result), 64'h4000_0000);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        fork
            begin
                send(mk(1'b0, 8'h7F, 32'h8000_0180, 1'b0, 2'd1, 1'b0, 32'h0), {3'b001, 32'h3F80_0001});
                send(mk(1'b0, 8'h01, 32'h4000_0000, 1'b0, 2'd0, 1'b0, 32'h0), {3'b000, 32'h0040_0000});
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("bp_no_gap", 64'(out_valid), 64'h1);
                end
            end
        join
        repeat (4) tick();

        // reset with both stages full
        out_ready = 1'b0;
        send(mk(1'b0, 8'hFE, 32'h0000_0000, 1'b1, 2'd1, 1'b0, 32'h0), {3'b101, 32'h7F7F_FFFF});
        send(mk(1'b0, 8'h7F, 32'h8000_0000, 1'b0, 2'd0, 1'b0, 32'h0), {3'b000, 32'h3F80_0000});
        check("mid_full", 64'(out_valid), 64'h1);
        rst_n = 1'b0;
        tick();
        check("mrst_valid", 64'(out_valid), 64'h0);
        check("mrst_result", 64'(out_result), 64'h0);
        check("mrst_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'h0);
        check("mrst_in_ready", 64'(in_ready), 64'h1);
        exp_q.delete();
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(mk(1'b0, 8'h7F, 32'h8000_0180, 1'b0, 2'd0, 1'b0, 32'h0), {3'b001, 32'h3F80_0002});
        check("post_rst_1cyc", 64'(out_valid), 64'h0);
        tick();
        check("post_rst_2cyc", 64'(out_valid), 64'h1);
        check("post_rst_result", 64'(out_result), 64'h3F80_0002);
        send(mk(1'b1, 8'h00, 32'hFFFF_FFFF, 1'b0, 2'd3, 1'b1, 32'h7FC0_0000), {3'b000, 32'h7FC0_0000});
        repeat (4) tick();

        // random beats with random backpressure
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    rb = rand_beat();
                    send(rb, ref_model(rb));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_normalize_pipe.md
# fp_normalize_pipe

Parametrised, two-stage pipelined normalize-and-round unit for the floating-point adder datapath. It sits between the align/add stage and the result register. It takes the raw aligned sum, carry, exponent and sign, and produces a packed IEEE-754-style result. It adds four rounding modes, exception flags, subnormal/underflow handling and a valid/ready handshake with full backpressure.

## Interface
Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa width; SUM_W = MAN_W+9 is derived (hidden bit, mantissa, 8 guard/extension bits)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  input beat present
- in_ready  out  1  unit accepts beat this cycle
- in_sign  in  1  sign of aligned result
- in_exp  in  EXP_W  pre-normalization exponent
- in_sum  in  SUM_W  aligned magnitude sum
- in_carry  in  1  carry out of the adder
- in_rmode  in  2  rounding mode: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (-inf)
- in_special  in  1  NaN/inf/zero bypass; result is in_special_val
- in_special_val  in  1+EXP_W+MAN_W  packed bypass result
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts
- out_result  out  1+EXP_W+MAN_W  {sign, exponent, mantissa}
- out_overflow, out_underflow, out_inexact  out  1 each  exception flags, qualified by out_valid

## Operation
- Stage 1 (normalize):
  - If in_carry, shift = 0; the hidden bit is in_carry, mantissa = in_sum[SUM_W-1:9], G = [8], R = [7], S = |[6:0], exp = in_exp+1.
  - Else: lzc = leading zeros of in_sum (SUM_W when zero).
    - If lzc < in_exp: shift = lzc, exp = in_exp-lzc.
    - Otherwise: exp = 0, shift = (in_exp==0) ? 0 : in_exp-1 (subnormal).
    - Shifted sum: hidden = [SUM_W-1], mantissa = [SUM_W-2:8], G = [7], R = [6], S = |[5:0].
  - Register sign, exp (EXP_W+1 bits), hidden, mantissa, G/R/S, rmode, special, special_val.
- Stage 2 (round):
  - Increment inc:
    - RNE: G&(R|S|lsb)
    - RTZ: 0
    - RUP: ~sign&(G|R|S)
    - RDN: sign&(G|R|S)
  - {c, h, m} = {hidden, mantissa} + inc.
    - If c: mantissa = 0 and exp+1.
    - Else if exp==0 and h: exp = 1 (subnormal rounds up to min normal).
  - inexact = G|R|S.
  - overflow = (final exp >= 2^EXP_W-1). The result on overflow is:
    - RNE: inf
    - RTZ: max finite (exp all-ones minus 1, mantissa all ones)
    - RUP: +inf if sign=0, otherwise -max finite
    - RDN: -inf if sign=1, otherwise +max finite
    - inexact = 1.
  - underflow = (final exp==0) & inexact.
- Exact cancellation (no carry, in_sum==0, not special): result is zero with sign = (rmode==RDN), flags all 0.
- Special beats pass in_special_val unchanged with flags 0 and no rounding.

## Timing
- Latency is 2 cycles from accepted input to out_valid. Throughput is 1 beat/cycle when out_ready=1.
- Each stage holds a valid bit.
  - s2_take = ~s2_valid | out_ready.
  - s1_take = ~s1_valid | s2_take.
  - in_ready = s1_take (combinational from out_ready).
- A beat is transferred when valid & ready are both high. Stage registers load only on take. Held data stays stable while out_valid & ~out_ready.
- Full: both stages valid and out_ready=0 gives in_ready=0; no beat is lost or duplicated, and order is preserved.
- rmode travels with its beat. Changing in_rmode between beats never affects beats already in flight.
- Reset (rst_n=0 at a clk edge) clears s1_valid, s2_valid, out_valid, all flags and out_result to 0, including mid-operation; in-flight beats are discarded. in_ready=1 in the cycle after reset.

## Test plan
- Normal, no carry: sum=32'h8000_0000, exp=8'h7F, RNE -> out_result 32'h3F80_0000, all flags 0, out_valid exactly 2 cycles after accept.
- Carry: carry=1, sum=0, exp=8'h7F -> 32'h4000_0000. Tie: sum=32'h8000_0180, exp=8'h7F -> RNE 32'h3F80_0002 inexact=1; RTZ 32'h3F80_0001 inexact=1.
- Overflow: carry=1, sum=0, exp=8'hFE, sign 0 -> RNE 32'h7F80_0000 overflow=1; RTZ 32'h7F7F_FFFF; sign 1 with RUP -> 32'hFF7F_FFFF.
- Subnormal/cancellation: exp=1, sum=32'h4000_0000 -> 32'h0040_0000, underflow=0. sum=0, carry=0, exp=8'h80 -> RNE 32'h0000_0000; RDN 32'h8000_0000.
- Backpressure: stream 4 beats with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts, out_result is held stable, all 4 results emerge in order once out_ready=1, with no gaps.
- Reset mid-flight: assert rst_n=0 with both stages valid -> next cycle out_valid=0 and out_result=0; a following beat returns the correct result after 2 cycles. A special beat with in_special_val=32'h7FC0_0000 passes through unchanged with flags 0.
